sumador_parametrizado: RTL and testbench
========================================

SUMADOR_PARAMETRIZADO -- requirements
Module: sumador_parametrizado

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the counter width in bits (N >= 2).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the stable-high cycles required to accept a press (>= 1).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port load, input, 1 bit: synchronous load of data_in into data_out.
REQ-006 The block SHALL have port data_in, input, N bits: the value to load.
REQ-007 The block SHALL have port btn_add, input, 1 bit: raw push-button, asynchronous to clk, active-high.
REQ-008 The block SHALL have port data_out, output, N bits: the current count.
REQ-009 The block SHALL have port overflow, output, 1 bit: sticky flag, set when an increment is attempted at all-ones.

Function
REQ-010 btn_add SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 The debounce FSM SHALL have exactly the states IDLE, CHECK and HELD.
REQ-012 In IDLE, a synchronized high SHALL move the FSM to CHECK and clear the debounce counter; a synchronized low SHALL keep it in IDLE.
REQ-013 In CHECK, a synchronized low SHALL return the FSM to IDLE with no increment.
REQ-014 In CHECK, the debounce counter SHALL reach DEBOUNCE_CYCLES-1 and the FSM SHALL then go to HELD, issuing exactly one single-cycle inc pulse.
REQ-015 In HELD, the FSM SHALL stay until the synchronized input is low, then go to IDLE; holding the button SHALL never produce a second increment.
REQ-016 With btn_add held high, data_out SHALL update at exactly rising edge DEBOUNCE_CYCLES+3, counting the first edge that samples btn_add high as edge 1.
REQ-017 An inc pulse SHALL set data_out to data_out+1, modulo 2^N.
REQ-018 An inc pulse with data_out all-ones SHALL also set overflow to 1.
REQ-019 load=1 SHALL set data_out to data_in and clear overflow on that edge.
REQ-020 When load and inc coincide, load SHALL win; that increment SHALL be discarded, not deferred.
REQ-021 load SHALL NOT affect the debounce FSM state.
REQ-022 overflow SHALL stay at 1 until load or reset.
REQ-023 A press shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave data_out and overflow unchanged.

Reset
REQ-024 While rst=0, data_out SHALL be 0 and overflow SHALL be 0, independent of clk.
REQ-025 While rst=0, the synchronizer flops SHALL be 0, the debounce counter SHALL be 0, and the FSM SHALL be in IDLE.
REQ-026 Reset asserted mid-debounce or in HELD SHALL abort the press.
REQ-027 After rst rises, a button still held SHALL need a full new debounce sequence before it increments.

Configuration
REQ-028 The macro SUMADOR_SAT_EN SHALL select saturation when defined.
REQ-029 With SUMADOR_SAT_EN defined, an inc at all-ones SHALL hold data_out at all-ones and set overflow.
REQ-030 Without SUMADOR_SAT_EN, an inc at all-ones SHALL wrap data_out to 0 and set overflow.
REQ-031 All other behaviour SHALL be identical with and without SUMADOR_SAT_EN.

Structure
REQ-032 Package sumador_pkg SHALL hold the debounce FSM state enum typedef (IDLE, CHECK, HELD).
REQ-033 The synchronizer, debounce FSM and counter SHALL form sub-module btn_debounce, parameterized by DEBOUNCE_CYCLES, with outputs the inc pulse only.
REQ-034 The top module SHALL hold the N-bit count register, load priority, wrap/saturation logic and overflow flag.

Verification (N=4, DEBOUNCE_CYCLES=4)
REQ-035 Reset then load: rst=0 for 2 cycles, release, load=1 with data_in=4'd13 for 1 cycle -> data_out=13, overflow=0.
REQ-036 Clean press: btn_add high for 10 cycles from data_out=13 -> data_out=14 at edge 7, with no further change while held.
REQ-037 Glitch rejection: btn_add high for 2 cycles from data_out=14 -> data_out stays 14.
REQ-038 Boundary: two clean presses from data_out=14 -> 15, then 0 with overflow=1 (SAT off) or 15 with overflow=1 (SAT on); a later load of 5 -> data_out=5, overflow=0.
REQ-039 Collision: load=1 with data_in=3 on the same edge as the inc pulse -> data_out=3, and there is no later increment.
REQ-040 Reset mid-debounce: rst=0 during CHECK while the button stays high -> data_out=0 after reset; after release, 7 more edges with the button high -> data_out=1.

Source files
------------

// File: rtl/sumador_pkg.sv
// Shared types for sumador_parametrizado: debounce FSM state encoding and
// a helper that sizes the debounce counter.
package sumador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HELD  = 2'd2
  } deb_state_e;

  // A single-cycle debounce still needs a 1-bit counter to stay legal.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-flop synchronizer, IDLE/CHECK/HELD debounce FSM
// and its stable-cycle counter; emits one single-cycle inc pulse per press.
module btn_debounce
  import sumador_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_inc
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  deb_state_e      r_state;
  logic [CntW-1:0] r_cnt;
  deb_state_e      w_state_d;
  logic [CntW-1:0] w_cnt_d;
  logic            w_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      IDLE: begin
        if (r_sync2) begin
          w_state_d = CHECK;
          w_cnt_d   = '0;
        end
      end
      CHECK: begin
        if (!r_sync2) begin
          w_state_d = IDLE;
        end else if (r_cnt == CntLast) begin
          w_state_d = HELD;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      HELD: begin
        if (!r_sync2) begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Pulse is asserted only on the CHECK->HELD transition, so at most once per press.
  always_comb begin
    w_inc = 1'b0;
    if ((r_state == CHECK) && r_sync2 && (r_cnt == CntLast)) begin
      w_inc = 1'b1;
    end
  end

  assign o_inc = w_inc;

endmodule

// File: rtl/sumador_parametrizado.sv
// Debounced push-button counter with synchronous load and sticky overflow.
// Define SUMADOR_SAT_EN to saturate at all-ones instead of wrapping to zero.
module sumador_parametrizado
  import sumador_pkg::*;
#(
  parameter int unsigned N               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] data_in,
  input  logic         btn_add,
  output logic [N-1:0] data_out,
  output logic         overflow
);

  logic [N-1:0] r_count;
  logic         r_ovf;
  logic [N-1:0] w_count_d;
  logic         w_ovf_d;
  logic         w_inc;
  logic         w_at_max;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst  (rst),
    .i_btn(btn_add),
    .o_inc(w_inc)
  );

  assign w_at_max = &r_count;

  // Load has priority; a coincident increment is dropped, not queued.
  always_comb begin
    w_count_d = r_count;
    w_ovf_d   = r_ovf;
    if (load) begin
      w_count_d = data_in;
      w_ovf_d   = 1'b0;
    end else if (w_inc) begin
      if (w_at_max) begin
        w_ovf_d = 1'b1;
`ifdef SUMADOR_SAT_EN
        w_count_d = r_count;
`else
        w_count_d = '0;
`endif
      end else begin
        w_count_d = r_count + N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_d;
      r_ovf   <= w_ovf_d;
    end
  end

  assign data_out = r_count;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_sumador_parametrizado.sv
// Directed bench for sumador_parametrizado (N=4, DEBOUNCE_CYCLES=4): vector
// table of loads/presses plus edge-exact timing, collision and reset sequences.
module tb_sumador_parametrizado;

  localparam int unsigned N   = 4;
  localparam int unsigned DEB = 4;

`ifdef SUMADOR_SAT_EN
  localparam logic [N-1:0] WrapVal = 4'd15;
`else
  localparam logic [N-1:0] WrapVal = 4'd0;
`endif

  logic         clk     = 1'b0;
  logic         rst     = 1'b0;
  logic         load    = 1'b0;
  logic [N-1:0] data_in = '0;
  logic         btn_add = 1'b0;
  logic [N-1:0] data_out;
  logic         overflow;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  sumador_parametrizado #(
    .N              (N),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data_in (data_in),
    .btn_add (btn_add),
    .data_out(data_out),
    .overflow(overflow)
  );

  typedef enum logic {OpLoad, OpPress} op_e;

  typedef struct {
    string        name;
    op_e          op;
    logic [N-1:0] din;
    int unsigned  cycles;
    logic [N-1:0] exp_out;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [N-1:0] exp_out, input logic exp_ovf);
    n_tests++;
    if (data_out !== exp_out || overflow !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s: data_out=%0d overflow=%0b, expected data_out=%0d overflow=%0b",
               name, data_out, overflow, exp_out, exp_ovf);
    end
  endtask

  initial begin
    vecs[0] = '{"load13",        OpLoad,  4'd13, 0,  4'd13,   1'b0};
    vecs[1] = '{"clean_press",   OpPress, 4'd0,  10, 4'd14,   1'b0};
    vecs[2] = '{"glitch2",       OpPress, 4'd0,  2,  4'd14,   1'b0};
    vecs[3] = '{"glitch1",       OpPress, 4'd0,  1,  4'd14,   1'b0};
    vecs[4] = '{"glitch3",       OpPress, 4'd0,  3,  4'd14,   1'b0};
    vecs[5] = '{"press_to_max",  OpPress, 4'd0,  10, 4'd15,   1'b0};
    vecs[6] = '{"press_at_max",  OpPress, 4'd0,  10, WrapVal, 1'b1};
    vecs[7] = '{"ovf_sticky",    OpPress, 4'd0,  10, (WrapVal == 4'd15) ? 4'd15 : 4'd1, 1'b1};
    vecs[8] = '{"load5_clr_ovf", OpLoad,  4'd5,  0,  4'd5,    1'b0};

    // Reset holds outputs at zero regardless of the clock.
    #1;
    check("reset_async", 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_held", 4'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("after_release", 4'd0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].op == OpLoad) begin
        data_in = vecs[i].din;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
      end else begin
        btn_add = 1'b1;
        repeat (vecs[i].cycles) @(negedge clk);
        btn_add = 1'b0;
        repeat (8) @(negedge clk);
      end
      check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_ovf);
    end

    // Edge-exact latency: update lands on edge DEB+3 and never repeats while held.
    btn_add = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("timing_edge%0d", k), 4'd5, 1'b0);
    end
    @(negedge clk);
    check("timing_edge7", 4'd6, 1'b0);
    for (int k = 8; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("held_edge%0d", k), 4'd6, 1'b0);
    end
    btn_add = 1'b0;
    repeat (6) @(negedge clk);

    // Load coinciding with the inc pulse wins and the increment is lost.
    btn_add = 1'b1;
    repeat (6) @(negedge clk);
    check("collide_pre", 4'd6, 1'b0);
    data_in = 4'd3;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    check("collide_load", 4'd3, 1'b0);
    repeat (5) @(negedge clk);
    check("collide_no_late_inc", 4'd3, 1'b0);
    btn_add = 1'b0;
    repeat (6) @(negedge clk);
    check("collide_release", 4'd3, 1'b0);

    // Reset in CHECK aborts the press; held button needs a full new debounce.
    btn_add = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_async", 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("postreset_edge%0d", k), 4'd0, 1'b0);
    end
    @(negedge clk);
    check("postreset_edge7", 4'd1, 1'b0);
    repeat (4) @(negedge clk);
    check("postreset_held", 4'd1, 1'b0);
    btn_add = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
